// File: rtl/regfile_access_ctrl_pkg.sv
// rtl/regfile_access_ctrl_pkg.sv - shared encodings and default widths for the register-file access controller
package regfile_access_ctrl_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 3;

   typedef enum logic [1:0] {
      OP_WRITE    = 2'b00,
      OP_READ     = 2'b01,
      OP_WRVERIFY = 2'b10,
      OP_CLEAR    = 2'b11
   } cmdOp_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      READ    = 3'd2,
      RD_WAIT = 3'd3,
      CLEAR   = 3'd4,
      RESP    = 3'd5
   } state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - command/response front end driving a register file (write, read, write-verify, clear-all)
// Every output is a register loaded from its *Nxt value, computed alongside the next state.
module regfile_access_ctrl
   import regfile_access_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  Cmd_Valid,
   output logic                  Cmd_Ready,
   input  logic [1:0]            Cmd_Op,
   input  logic [ADDR_WIDTH-1:0] Cmd_Addr,
   input  logic [DATA_WIDTH-1:0] Cmd_Data,
   output logic                  Rsp_Valid,
   input  logic                  Rsp_Ready,
   output logic [DATA_WIDTH-1:0] Rsp_Data,
   output logic                  Rsp_Err,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0] WrData,
   input  logic [DATA_WIDTH-1:0] RdData
);

   localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                state, stateNxt;
   cmdOp_t                opReg, opNxt;
   logic [ADDR_WIDTH-1:0] addrReg, addrNxt;
   logic [DATA_WIDTH-1:0] dataReg, dataNxt;
   logic [ADDR_WIDTH:0]   clrCnt, clrCntNxt;

   logic                  cmdReadyNxt, rspValidNxt, rspErrNxt, wrEnNxt, rdEnNxt;
   logic [ADDR_WIDTH-1:0] addressNxt;
   logic [DATA_WIDTH-1:0] wrDataNxt, rspDataNxt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         opReg     <= OP_WRITE;
         addrReg   <= '0;
         dataReg   <= '0;
         clrCnt    <= '0;
         Cmd_Ready <= 1'b1;
         Rsp_Valid <= 1'b0;
         Rsp_Data  <= '0;
         Rsp_Err   <= 1'b0;
         WrEn      <= 1'b0;
         RdEn      <= 1'b0;
         Address   <= '0;
         WrData    <= '0;
      end else begin
         state     <= stateNxt;
         opReg     <= opNxt;
         addrReg   <= addrNxt;
         dataReg   <= dataNxt;
         clrCnt    <= clrCntNxt;
         Cmd_Ready <= cmdReadyNxt;
         Rsp_Valid <= rspValidNxt;
         Rsp_Data  <= rspDataNxt;
         Rsp_Err   <= rspErrNxt;
         WrEn      <= wrEnNxt;
         RdEn      <= rdEnNxt;
         Address   <= addressNxt;
         WrData    <= wrDataNxt;
      end
   end

   always_comb begin
      stateNxt    = state;
      opNxt       = opReg;
      addrNxt     = addrReg;
      dataNxt     = dataReg;
      clrCntNxt   = clrCnt;
      cmdReadyNxt = 1'b0;
      rspValidNxt = 1'b0;
      rspDataNxt  = Rsp_Data;
      rspErrNxt   = Rsp_Err;
      wrEnNxt     = 1'b0;
      rdEnNxt     = 1'b0;
      addressNxt  = '0;
      wrDataNxt   = '0;

      case (state)
         IDLE: begin
            rspDataNxt = '0;
            rspErrNxt  = 1'b0;
            if (Cmd_Valid && Cmd_Ready) begin
               opNxt   = cmdOp_t'(Cmd_Op);
               addrNxt = Cmd_Addr;
               dataNxt = Cmd_Data;
               case (cmdOp_t'(Cmd_Op))
                  OP_READ: begin
                     stateNxt   = READ;
                     rdEnNxt    = 1'b1;
                     addressNxt = Cmd_Addr;
                  end
                  OP_CLEAR: begin
                     stateNxt  = CLEAR;
                     wrEnNxt   = 1'b1;
                     clrCntNxt = CNT_ONE;
                  end
                  default: begin
                     stateNxt   = WRITE;
                     wrEnNxt    = 1'b1;
                     addressNxt = Cmd_Addr;
                     wrDataNxt  = Cmd_Data;
                  end
               endcase
            end else begin
               cmdReadyNxt = 1'b1;
            end
         end

         WRITE: begin
            if (opReg == OP_WRVERIFY) begin
               stateNxt   = READ;
               rdEnNxt    = 1'b1;
               addressNxt = addrReg;
            end else begin
               stateNxt    = RESP;
               rspValidNxt = 1'b1;
               rspDataNxt  = '0;
               rspErrNxt   = 1'b0;
            end
         end

         READ: stateNxt = RD_WAIT;

         RD_WAIT: begin
            stateNxt    = RESP;
            rspValidNxt = 1'b1;
            rspDataNxt  = RdData;
            rspErrNxt   = (opReg == OP_WRVERIFY) && (RdData != dataReg);
         end

         // clrCnt runs one ahead of Address; its MSB ends the sweep without wrapping.
         CLEAR: begin
            if (clrCnt[ADDR_WIDTH]) begin
               stateNxt    = RESP;
               rspValidNxt = 1'b1;
               rspDataNxt  = '0;
               rspErrNxt   = 1'b0;
            end else begin
               wrEnNxt    = 1'b1;
               addressNxt = clrCnt[ADDR_WIDTH-1:0];
               clrCntNxt  = clrCnt + CNT_ONE;
            end
         end

         RESP: begin
            if (Rsp_Ready) begin
               stateNxt    = IDLE;
               cmdReadyNxt = 1'b1;
               rspDataNxt  = '0;
               rspErrNxt   = 1'b0;
            end else begin
               rspValidNxt = 1'b1;
            end
         end

         default: begin
            stateNxt    = IDLE;
            cmdReadyNxt = 1'b1;
         end
      endcase
   end

endmodule

// File: doc/regfile_access_ctrl.md
REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- DATA_WIDTH, 16, register data width.
- ADDR_WIDTH, 3, register address width; depth is 2**ADDR_WIDTH.
REQ-002 The block SHALL have these ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Cmd_Valid  in  1  command request.
- Cmd_Ready  out  1  command accepted when high with Cmd_Valid at a rising edge.
- Cmd_Op  in  2  command code: 00 write, 01 read, 10 write-verify, 11 clear-all.
- Cmd_Addr  in  ADDR_WIDTH  target address; ignored for clear-all.
- Cmd_Data  in  DATA_WIDTH  write data; ignored for read and clear-all.
- Rsp_Valid  out  1  response available.
- Rsp_Ready  in  1  response consumed when high with Rsp_Valid at a rising edge.
- Rsp_Data  out  DATA_WIDTH  read data; zero for write and clear-all.
- Rsp_Err  out  1  write-verify mismatch flag.
- WrEn  out  1  register-file write strobe.
- RdEn  out  1  register-file read strobe.
- Address  out  ADDR_WIDTH  register-file address.
- WrData  out  DATA_WIDTH  register-file write data.
- RdData  in  DATA_WIDTH  register-file read data, valid one cycle after an RdEn edge.

Function
REQ-003 The FSM SHALL have the states IDLE, WRITE, READ, RD_WAIT, CLEAR and RESP.
REQ-004 Cmd_Ready SHALL be high only in IDLE, and acceptance SHALL latch Cmd_Op, Cmd_Addr and Cmd_Data.
REQ-005 Write: IDLE->WRITE, with WrEn=1, Address and WrData driven for exactly one cycle, then ->RESP.
REQ-006 Read: IDLE->READ, with RdEn=1 for one cycle, then ->RD_WAIT; RdData SHALL be captured into Rsp_Data at the end of RD_WAIT, then ->RESP.
REQ-007 Write-verify: WRITE, then READ and RD_WAIT at the same address; Rsp_Data SHALL equal the captured RdData, and Rsp_Err=1 if and only if the captured RdData differs from the latched data.
REQ-008 Clear-all: CLEAR SHALL assert WrEn with WrData=0 for 2**ADDR_WIDTH consecutive cycles, Address counting 0 up to the maximum, then ->RESP.
REQ-009 The clear address counter SHALL be ADDR_WIDTH+1 bits and SHALL terminate on its MSB, with no wrap-around re-entry.
REQ-010 RESP SHALL hold Rsp_Valid=1 and stable Rsp_Data/Rsp_Err until Rsp_Ready=1, then ->IDLE.
REQ-011 A new command SHALL NOT be accepted in the same cycle a response is consumed.
REQ-012 Rsp_Valid rises 2 edges after acceptance for write and 3 edges after acceptance for read.
REQ-013 WrEn and RdEn SHALL never both be high in the same cycle.
REQ-014 Outside the WRITE, READ and CLEAR states, WrEn, RdEn, Address and WrData SHALL be 0.
REQ-015 All outputs SHALL be registered.

Reset
REQ-016 Asserting RST SHALL immediately, with no clock, force IDLE and zero all outputs except Cmd_Ready, which goes to 1 after reset deassertion.
REQ-017 RST asserted mid-operation, including mid-clear, SHALL abort with no further WrEn pulses and no response issued.
REQ-018 The first command SHALL be accepted at the first rising edge after RST deasserts.

Structure
REQ-019 A shared package SHALL hold the Cmd_Op encodings, the FSM state encoding, and the DATA_WIDTH/ADDR_WIDTH defaults.
REQ-020 The block SHALL be a single module with no sub-modules.
REQ-021 The bench SHALL instantiate regfile_access_ctrl connected to Register_File.

Verification
REQ-022 Write 0x000B to addr 5, then read addr 5 -> Rsp_Data=0x000B, Rsp_Err=0, WrEn high exactly one cycle.
REQ-023 Write-verify 0x001F to addr 2 -> Rsp_Data=0x001F, Rsp_Err=0, Rsp_Valid 4 edges after acceptance.
REQ-024 Clear-all after writing 0xFFFF to every address -> eight WrEn cycles at addresses 0..7, then a read of each address returns 0x0000.
REQ-025 Hold Rsp_Ready=0 for 5 cycles during RESP -> Rsp_Valid and Rsp_Data stay stable, Cmd_Ready stays 0 and a pending Cmd_Valid is not accepted.
REQ-026 Assert RST at the fourth CLEAR cycle -> outputs zero immediately and no Rsp_Valid pulse; a later write 0x1234 to addr 7 completes normally.
REQ-027 Write-verify with RdData forced to 0xDEAD -> Rsp_Err=1 and Rsp_Data=0xDEAD.
